// File: rtl/edf_ic_claim.sv
// Claim/complete responder for the EDF interrupt controller. This block presents the winning ID
// to the core, clears the claimed source, and tracks the interrupt that is in service.
// Optional claim timeout is built when EDF_IC_CLAIM_TIMEOUT_EN is defined.
module edf_ic_claim #(
    parameter int NrParIrqs     = 2,
    parameter int TimeoutCycles = 16,
    localparam int IdWidth      = (NrParIrqs > 1) ? $clog2(NrParIrqs) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 irq_valid_i,
    input  logic [IdWidth-1:0]   irq_id_i,
    input  logic [NrParIrqs-1:0] irq_pend_i,
    output logic                 irq_req_o,
    output logic [IdWidth-1:0]   irq_req_id_o,
    input  logic                 irq_ack_i,
    input  logic                 irq_cmpl_i,
    input  logic [IdWidth-1:0]   irq_cmpl_id_i,
    output logic [NrParIrqs-1:0] irq_clr_o,
    output logic                 busy_o,
    output logic                 err_o,
    output logic                 timeout_o
);

    // Handshake: irq_req_o stays high with a stable irq_req_id_o until the cycle after
    // irq_ack_i is sampled high, or until the source withdraws or times out.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_CLAIM   = 2'd2;
    localparam logic [1:0] ST_SERVICE = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [IdWidth-1:0]   id_q, id_d;
    logic                 req_q, req_d;
    logic [NrParIrqs-1:0] clr_q, clr_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic                 id_ok;

    assign id_ok = (int'(irq_id_i) < NrParIrqs) && irq_pend_i[irq_id_i];

`ifdef EDF_IC_CLAIM_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
    logic            cnt_expire;

    // The counter holds the number of REQ cycles already elapsed, so the last allowed cycle
    // is the one where the count equals TimeoutCycles-1.
    assign cnt_expire = (cnt_q == CntW'(TimeoutCycles - 1));
`endif

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        req_d   = req_q;
        clr_d   = '0;
        err_d   = err_q;
`ifdef EDF_IC_CLAIM_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        if (irq_cmpl_i && (state_q != ST_SERVICE)) begin
            err_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (irq_valid_i && id_ok) begin
                    state_d = ST_REQ;
                    id_d    = irq_id_i;
                    req_d   = 1'b1;
`ifdef EDF_IC_CLAIM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_REQ: begin
                if (irq_ack_i) begin
                    state_d      = ST_CLAIM;
                    req_d        = 1'b0;
                    clr_d[id_q]  = 1'b1;
                end else if (!irq_pend_i[id_q]) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end
`ifdef EDF_IC_CLAIM_TIMEOUT_EN
                else if (cnt_expire) begin
                    state_d   = ST_IDLE;
                    req_d     = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_CLAIM: begin
                state_d = ST_SERVICE;
            end
            ST_SERVICE: begin
                if (irq_cmpl_i) begin
                    if (irq_cmpl_id_i == id_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            req_q   <= 1'b0;
            clr_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            req_q   <= req_d;
            clr_q   <= clr_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

`ifdef EDF_IC_CLAIM_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign irq_req_o    = req_q;
    assign irq_req_id_o = id_q;
    assign irq_clr_o    = clr_q;
    assign busy_o       = busy_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_edf_ic_claim.sv
// Bench for edf_ic_claim: directed scenarios, then random traffic, all checked cycle by cycle
// against a transaction-level reference model. Honors EDF_IC_CLAIM_TIMEOUT_EN.
module tb_edf_ic_claim;
    localparam int N  = 2;
    localparam int T  = 4;
    localparam int IW = 1;
`ifdef EDF_IC_CLAIM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic [IW-1:0] id;
    logic [N-1:0]  pend;
    logic          req;
    logic [IW-1:0] req_id;
    logic          ack;
    logic          cmpl;
    logic [IW-1:0] cmpl_id;
    logic [N-1:0]  clr;
    logic          busy;
    logic          err;
    logic          tmo;

    always #5 clk = ~clk;

    edf_ic_claim #(.NrParIrqs(N), .TimeoutCycles(T)) dut (
        .clk_i(clk), .rst_i(rst), .irq_valid_i(valid), .irq_id_i(id), .irq_pend_i(pend),
        .irq_req_o(req), .irq_req_id_o(req_id), .irq_ack_i(ack), .irq_cmpl_i(cmpl),
        .irq_cmpl_id_i(cmpl_id), .irq_clr_o(clr), .busy_o(busy), .err_o(err), .timeout_o(tmo)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the interrupt's lifecycle is tracked as a set of flags
    // (offered to the core, being claimed, in service) plus the age of the offer.
    bit            m_offered, m_claiming, m_serving, m_err, m_to;
    logic [IW-1:0] m_id;
    logic [N-1:0]  m_clr;
    int            m_age;

    task automatic model_edge();
        logic [N-1:0] clr_now;
        bit           to_now;
        clr_now = '0;
        to_now  = 1'b0;
        if (rst) begin
            m_offered = 0; m_claiming = 0; m_serving = 0; m_err = 0; m_id = '0; m_age = 0;
        end else begin
            if (cmpl && !m_serving) m_err = 1;
            if (m_claiming) begin
                m_claiming = 0;
                m_serving  = 1;
            end else if (m_serving) begin
                if (cmpl) begin
                    if (cmpl_id == m_id) m_serving = 0;
                    else m_err = 1;
                end
            end else if (m_offered) begin
                m_age++;
                if (ack) begin
                    m_offered = 0; m_claiming = 1; clr_now[m_id] = 1'b1;
                end else if (!pend[m_id]) begin
                    m_offered = 0;
                end else if (TO_EN && m_age == T) begin
                    m_offered = 0; to_now = 1'b1;
                end
            end else if (valid && int'(id) < N && pend[id]) begin
                m_offered = 1; m_id = id; m_age = 0;
            end
        end
        m_clr = clr_now;
        m_to  = to_now;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".req"},    32'(req),    32'(m_offered));
        check({tag, ".req_id"}, 32'(req_id), 32'(m_id));
        check({tag, ".clr"},    32'(clr),    32'(m_clr));
        check({tag, ".busy"},   32'(busy),   32'(m_offered | m_claiming | m_serving));
        check({tag, ".err"},    32'(err),    32'(m_err));
        check({tag, ".tmo"},    32'(tmo),    32'(m_to));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        rst = 0; valid = 0; id = '0; pend = '0; ack = 0; cmpl = 0; cmpl_id = '0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        step("rst0");
        step("rst1");
        check("reset_req", 32'(req), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_id",  32'(req_id), 32'd0);
        rst = 0;

        // Basic claim of id 1, ack two cycles after req rises
        valid = 1; id = 1'b1; pend = 2'b10;
        step("basic_accept");
        check("basic_req", 32'(req), 32'd1);
        check("basic_id",  32'(req_id), 32'd1);
        valid = 0;
        step("basic_wait");
        ack = 1;
        step("basic_ack");
        check("basic_clr", 32'(clr), 32'h2);
        ack = 0;
        step("basic_service");
        check("basic_clr_once", 32'(clr), 32'h0);
        cmpl = 1; cmpl_id = 1'b1;
        step("basic_cmpl");
        check("basic_busy", 32'(busy), 32'd0);
        cmpl = 0;

        // Withdraw without ack
        valid = 1; id = 1'b1; pend = 2'b10;
        step("wd_accept");
        valid = 0; pend = 2'b00;
        step("wd_drop");
        check("wd_req", 32'(req), 32'd0);
        step("wd_after");
        check("wd_clr", 32'(clr), 32'h0);

        // Ack in the drop cycle: claim wins
        valid = 1; pend = 2'b10;
        step("ad_accept");
        valid = 0; pend = 2'b00; ack = 1;
        step("ad_ack");
        check("ad_clr", 32'(clr), 32'h2);
        ack = 0;
        step("ad_service");
        cmpl = 1; cmpl_id = 1'b1;
        step("ad_cmpl");
        cmpl = 0;

        // Bad completion while servicing id 0
        valid = 1; id = 1'b0; pend = 2'b01;
        step("bc_accept");
        valid = 0; ack = 1;
        step("bc_ack");
        ack = 0;
        step("bc_service");
        cmpl = 1; cmpl_id = 1'b1;
        step("bc_bad");
        check("bc_err", 32'(err), 32'd1);
        check("bc_busy", 32'(busy), 32'd1);
        cmpl_id = 1'b0;
        step("bc_good");
        check("bc_idle", 32'(busy), 32'd0);
        check("bc_sticky", 32'(err), 32'd1);
        cmpl = 0;

        // Reset during CLAIM
        valid = 1; id = 1'b1; pend = 2'b10;
        step("rc_accept");
        valid = 0; ack = 1;
        step("rc_claim");
        ack = 0; rst = 1;
        step("rc_reset");
        check("rc_clr", 32'(clr), 32'h0);
        check("rc_err", 32'(err), 32'd0);
        check("rc_busy", 32'(busy), 32'd0);
        rst = 0; valid = 1;
        step("rc_fresh");
        check("rc_fresh_req", 32'(req), 32'd1);
        valid = 0; ack = 1;
        step("rc_fresh_ack");
        ack = 0;
        step("rc_fresh_svc");
        cmpl = 1; cmpl_id = 1'b1;
        step("rc_fresh_cmpl");
        cmpl = 0;

        // Back-to-back: id 0 held valid during service of id 1
        valid = 1; id = 1'b1; pend = 2'b11;
        step("bb_accept");
        id = 1'b0; ack = 1;
        step("bb_ack");
        ack = 0;
        for (int i = 0; i < 3; i++) begin
            step("bb_hold");
            check("bb_no_req", 32'(req), 32'd0);
        end
        cmpl = 1; cmpl_id = 1'b1;
        step("bb_cmpl");
        cmpl = 0;
        step("bb_reaccept");
        check("bb_req", 32'(req), 32'd1);
        check("bb_req_id", 32'(req_id), 32'd0);
        valid = 0; ack = 1;
        step("bb_ack2");
        ack = 0;
        step("bb_svc2");
        cmpl = 1; cmpl_id = 1'b0;
        step("bb_cmpl2");
        cmpl = 0;

`ifdef EDF_IC_CLAIM_TIMEOUT_EN
        valid = 1; id = 1'b1; pend = 2'b10;
        step("to_accept");
        valid = 0;
        for (int i = 0; i < T - 1; i++) step("to_wait");
        step("to_expire");
        check("to_pulse", 32'(tmo), 32'd1);
        check("to_req", 32'(req), 32'd0);
        step("to_after");
        check("to_once", 32'(tmo), 32'd0);
        valid = 1;
        step("toa_accept");
        valid = 0;
        for (int i = 0; i < T - 1; i++) step("toa_wait");
        ack = 1;
        step("toa_ack");
        check("toa_no_pulse", 32'(tmo), 32'd0);
        check("toa_clr", 32'(clr), 32'h2);
        ack = 0;
        step("toa_svc");
        cmpl = 1; cmpl_id = 1'b1;
        step("toa_cmpl");
        cmpl = 0;
`else
        valid = 1; id = 1'b1; pend = 2'b10;
        step("nto_accept");
        valid = 0;
        for (int i = 0; i < 20; i++) step("nto_wait");
        check("nto_still_req", 32'(req), 32'd1);
        pend = 2'b00;
        step("nto_withdraw");
`endif

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(0, 59) == 0);
            valid   = ($urandom_range(0, 1) == 1);
            id      = IW'($urandom_range(0, N - 1));
            pend    = ($urandom_range(0, 7) == 0) ? N'($urandom) : N'(2'b11);
            ack     = ($urandom_range(0, 3) == 0);
            cmpl    = ($urandom_range(0, 5) == 0);
            cmpl_id = ($urandom_range(0, 3) == 0) ? IW'($urandom_range(0, N - 1)) : m_id;
            step("rand");
        end

        idle_inputs();
        step("final");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
